// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 6;
  localparam int unsigned DEF_COUNTER_WIDTH = 3;
  localparam int unsigned PRODUCT_WIDTH     = 2 * DEF_DATA_WIDTH;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/multiplier_datapath.sv
// Operand/product registers and iteration counter for the shift-add multiplier.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      initialize,
  input  logic                      add_shift,
  input  logic                      accumulate,
  input  logic [DATA_WIDTH-1:0]     operand1,
  input  logic [DATA_WIDTH-1:0]     operand2,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      mult_lsb,
  output logic                      last_iter
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0]            multiplicand_q;
  logic [DATA_WIDTH-1:0]    multiplier_q;
  logic [PW-1:0]            product_q;
  logic [COUNTER_WIDTH-1:0] count_q;

  assign last_iter = (count_q == COUNTER_WIDTH'(DATA_WIDTH - 1));
  assign mult_lsb  = multiplier_q[0];
  assign product   = product_q;

  // Counter wraps to zero on the final iteration so it never passes DATA_WIDTH-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      multiplicand_q <= '0;
      multiplier_q   <= '0;
      product_q      <= '0;
      count_q        <= '0;
    end else if (initialize) begin
      multiplicand_q <= PW'(operand1);
      multiplier_q   <= operand2;
      product_q      <= '0;
      count_q        <= '0;
    end else if (add_shift) begin
      if (accumulate) begin
        product_q <= product_q + multiplicand_q;
      end
      multiplicand_q <= multiplicand_q << 1;
      multiplier_q   <= multiplier_q >> 1;
      count_q        <= last_iter ? '0 : count_q + COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/multiplier_unit.sv
// Sequential unsigned shift-add multiplier: control FSM around multiplier_datapath.
module multiplier_unit
  import mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   Operand1,
  input  logic [DATA_WIDTH-1:0]   Operand2,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    upper_nonzero
);

  state_t state_q;
  state_t state_d;
  logic   busy_d;
  logic   done_d;
  logic   initialize;
  logic   add_shift;
  logic   accumulate;
  logic   mult_lsb;
  logic   last_iter;

  // State register; busy/done registered from the next-state decode so they align with state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    initialize = 1'b0;
    add_shift  = 1'b0;
    accumulate = 1'b0;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    initialize = (state_q == IDLE) && start;
    add_shift  = (state_q == RUN);
    accumulate = add_shift && mult_lsb;
  end

  multiplier_datapath #(
    .DATA_WIDTH    (DATA_WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_datapath (
    .CLK        (CLK),
    .RST        (RST),
    .initialize (initialize),
    .add_shift  (add_shift),
    .accumulate (accumulate),
    .operand1   (Operand1),
    .operand2   (Operand2),
    .product    (product),
    .mult_lsb   (mult_lsb),
    .last_iter  (last_iter)
  );

  assign upper_nonzero = |product[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_multiplier_unit.sv
// Directed self-checking bench for multiplier_unit (DATA_WIDTH=6).
module tb_multiplier_unit;

  localparam int unsigned DW = 6;
  localparam int unsigned PW = 12;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [DW-1:0] Operand1;
  logic [DW-1:0] Operand2;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic          upper_nonzero;

  int n_cmp = 0;
  int n_err = 0;

  multiplier_unit #(.DATA_WIDTH(6), .COUNTER_WIDTH(3)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .Operand1      (Operand1),
    .Operand2      (Operand2),
    .busy          (busy),
    .done          (done),
    .product       (product),
    .upper_nonzero (upper_nonzero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1; start = 1'b1; Operand1 = 6'd5; Operand2 = 6'd3;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++;
      if (product !== 12'd0) begin n_err++; $display("FAIL reset_product: got %0d want 0", product); end
      n_cmp++;
      if (upper_nonzero !== 1'b0) begin n_err++; $display("FAIL reset_upper: got %b want 0", upper_nonzero); end
    end
    @(posedge CLK); #1;
    RST = 1'b0; start = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_start: busy got %b want 0", busy); end
    @(posedge CLK); #1;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic test_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [PW-1:0] exp, input logic exp_up, input string name);
    Operand1 = a; Operand2 = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; Operand1 = ~a; Operand2 = ~b;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (busy !== (c <= 7)) begin n_err++; $display("FAIL %s busy c%0d: got %b want %b", name, c, busy, (c <= 7)); end
      n_cmp++;
      if (done !== (c == 7)) begin n_err++; $display("FAIL %s done c%0d: got %b want %b", name, c, done, (c == 7)); end
      if (c == 7) begin
        n_cmp++;
        if (product !== exp) begin n_err++; $display("FAIL %s product: got %0d want %0d", name, product, exp); end
        n_cmp++;
        if (upper_nonzero !== exp_up) begin n_err++; $display("FAIL %s upper_nonzero: got %b want %b", name, upper_nonzero, exp_up); end
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    n_cmp++;
    if (product !== exp) begin n_err++; $display("FAIL %s product_hold: got %0d want %0d", name, product, exp); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    Operand1 = 6'd7; Operand2 = 6'd9; start = 1'b1;
    @(posedge CLK); #1;
    Operand1 = 6'd2; Operand2 = 6'd10;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (busy !== (c != 8)) begin n_err++; $display("FAIL b2b busy c%0d: got %b want %b", c, busy, (c != 8)); end
      n_cmp++;
      if (done !== (c == 7 || c == 15)) begin n_err++; $display("FAIL b2b done c%0d: got %b want %b", c, done, (c == 7 || c == 15)); end
      if (c == 7 || c == 8) begin
        n_cmp++;
        if (product !== 12'd63) begin n_err++; $display("FAIL b2b first product c%0d: got %0d want 63", c, product); end
      end
      if (c == 15) begin
        n_cmp++;
        if (product !== 12'd20) begin n_err++; $display("FAIL b2b second product: got %0d want 20", product); end
        start = 1'b0;
      end
      if (c == 10) begin
        Operand1 = 6'd63; Operand2 = 6'd63;
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b idle_after: busy got %b want 0", busy); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_run();
    Operand1 = 6'd12; Operand2 = 6'd11; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midrst busy_before: got %b want 1", busy); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL midrst busy c%0d: got %b want 0", c, busy); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL midrst done c%0d: got %b want 0", c, done); end
      n_cmp++;
      if (product !== 12'd0) begin n_err++; $display("FAIL midrst product c%0d: got %0d want 0", c, product); end
      @(posedge CLK); #1;
    end
    test_op(6'd12, 6'd11, 12'd132, 1'b1, "12x11_after_reset");
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; Operand1 = '0; Operand2 = '0;
    test_reset();
    test_op(6'd5,  6'd3,  12'd15,   1'b0, "5x3");
    test_op(6'd63, 6'd63, 12'd3969, 1'b1, "63x63");
    test_op(6'd0,  6'd45, 12'd0,    1'b0, "0x45");
    test_op(6'd45, 6'd0,  12'd0,    1'b0, "45x0");
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
